seq_gen: RTL
============

# seq_gen

Serial pattern transmitter: accepts a parallel word plus a repeat count over a valid/ready handshake, then shifts the word out LSB-first for (reps+1) back-to-back repetitions, one bit per clock. It is the source end of the serial sequence-detection path. Its `ser_out` drives a detector's serial input directly, and LSB-first order makes a detector that shifts in from the MSB see the word in its original bit order. It also serves as the stimulus generator for detector benches.

## Interface
- `WIDTH`, default 12: word length in bits, ≥ 2.
- `CNT_W`, default 4: repeat-count width.
- `clk` input, 1 bit: clock; all logic on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `load_valid` input, 1 bit: request to load a new word.
- `load_ready` output, 1 bit: block can accept a load this cycle.
- `load_data` input, `WIDTH` bits: word to transmit, bit 0 first.
- `load_reps` input, `CNT_W` bits: extra repetitions (0 means send once).
- `abort` input, 1 bit: synchronous cancel of the current transmission.
- `ser_out` output, 1 bit: serial data bit.
- `ser_valid` output, 1 bit: `ser_out` carries a pattern bit this cycle.
- `ser_last` output, 1 bit: this is the final bit of the final repetition.
- `busy` output, 1 bit: a transmission is in progress.

## Operation
- **States:** IDLE and SEND.
- **Reset values:** state IDLE; `ser_out`, `ser_valid`, `ser_last` and `busy` are 0; `load_ready` is 1; shift, bit and repeat registers are 0.
- **Accept:** a load is accepted when `load_valid && load_ready`.
  - `load_data` is captured into a hold register and a shift register.
  - `load_reps` is captured into the repeat counter.
  - The bit counter is set to 0 and the state goes to SEND.
- **SEND:**
  - `ser_out` = shift[0] and `ser_valid` = 1.
  - Each cycle the shift register shifts right by one and the bit counter increments.
  - When the bit counter reaches `WIDTH`-1:
    - If the repeat counter ≠ 0: reload the shift register from the hold register, decrement the repeat counter, clear the bit counter. There is no gap cycle.
    - If the repeat counter = 0: assert `ser_last` and return to IDLE, unless a new load is accepted that same cycle.
- **`load_ready`:** equals (state == IDLE) OR (state == SEND AND `ser_last`). This allows gapless chaining: a load accepted on the `ser_last` cycle puts its bit 0 on the very next cycle.
- **`busy`:** equals (state == SEND).
- **IDLE outputs:** `ser_out` = 0, `ser_valid` = 0, `ser_last` = 0.
- **`abort`:**
  - When `abort` = 1 in SEND, the next cycle is IDLE with all serial outputs 0 and no `ser_last`.
  - `abort` has priority over a simultaneous load, and that load is not accepted.
  - `abort` in IDLE has no effect.
- **Reset mid-transmission:** all state is discarded immediately and outputs go to their reset values asynchronously.
- **Load data stability:** `load_data` and `load_reps` changing while not accepted have no effect.

## Timing
- Load accepted at edge E (cycle T): bit k of repetition r appears in cycle T+1+r·`WIDTH`+k.
- Total bits sent = `WIDTH`·(reps+1). `ser_last` is high in cycle T+`WIDTH`·(reps+1), together with bit `WIDTH`-1.
- Latency from accept to first bit: 1 cycle.
- Throughput: 1 bit/cycle with no idle cycles between repetitions or between chained loads.
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs, except that `load_ready` depends only on state.
- Reset: `load_ready` is 1 in the first cycle after `reset` deasserts.

## Structure
- **Package `seq_pkg`:**
  - state enum {IDLE, SEND};
  - `SEQ_WIDTH` = 12;
  - `SEQ_PATTERN` = 12'b1110_1101_1011, the detector's target word, for shared use by bench and top level.
- **Bit counter width:** $clog2(`WIDTH`).
- **Sub-module `seq_piso`:** parallel-in serial-out shift register with a load and shift enable. Control (FSM, counters, handshake) stays in `seq_gen`.

## Test plan
- **Single word:** load `SEQ_PATTERN` with reps=0 at cycle T.
  - Cycles T+1..T+12 carry 1,1,0,1,1,0,1,1,0,1,1,1.
  - `ser_last` is high only at T+12.
  - With the detector attached, `det_out` = 1 in cycle T+13 only.
- **Repeats:** reps=2.
  - 36 contiguous valid bits; `ser_valid` never drops.
  - `det_out` is high at T+13, T+25 and T+37.
  - `ser_last` is high at T+36 only; `busy` drops at T+37.
- **Chaining:** hold `load_valid`=1 with a second word 12'h001.
  - It is accepted on the `ser_last` cycle.
  - Its bit 0 (=1) appears the next cycle, with no `ser_valid` gap.
- **Abort:** `abort` at bit 5, with `load_valid`=1 in the same cycle.
  - Next cycle: IDLE, `ser_valid`=0, no `ser_last`, load not accepted.
  - `load_ready`=1 the following cycle.
- **Reset mid-SEND:** assert `reset` at bit 7 of repetition 1.
  - Outputs are 0 and `load_ready` is 1 immediately.
  - A fresh load after release transmits from bit 0.
- **Backpressure:** `load_valid` asserted while `busy` and not on the `ser_last` cycle, with `load_data` toggling.
  - No capture; the transmitted stream is unchanged.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial pattern transmitter and its users.
package seq_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } seq_state_e;

  localparam int unsigned SEQ_WIDTH = 12;

  // Target word of the downstream sequence detector.
  localparam logic [SEQ_WIDTH-1:0] SEQ_PATTERN = 12'b1110_1101_1011;

endpackage

// File: rtl/seq_gen_if.sv
// Load handshake between a word producer and seq_gen.
interface seq_gen_if #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned CNT_W = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [CNT_W-1:0] load_reps;

  modport master (
    output load_valid,
    output load_data,
    output load_reps,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_reps,
    output load_ready
  );
endinterface

// File: rtl/seq_gen_piso.sv
// Parallel-in serial-out shift register; load wins over shift, bit 0 leaves first.
module seq_piso #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);
  logic [WIDTH-1:0] shift_q, shift_d;

  always_comb begin
    shift_d = shift_q;
    if (load) begin
      shift_d = din;
    end else if (shift_en) begin
      shift_d = shift_q >> 1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign sout = shift_q[0];
endmodule

// File: rtl/seq_gen.sv
// Serial pattern transmitter: sends a loaded word LSB-first (reps+1) times back to back.
module seq_gen
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_WIDTH,
  parameter int unsigned CNT_W = 4
) (
  input  logic     clk,
  input  logic     reset,
  seq_gen_if.slave ld,
  input  logic     abort,
  output logic     ser_out,
  output logic     ser_valid,
  output logic     ser_last,
  output logic     busy
);
  localparam int unsigned BIT_W = $clog2(WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] rep_q, rep_d;

  logic             piso_load, piso_shift, piso_bit;
  logic [WIDTH-1:0] piso_din;
  logic             sending, last_bit, final_bit, accept;

  assign sending   = (state_q == SEND);
  assign last_bit  = (bit_q == LAST_BIT);
  assign final_bit = sending && last_bit && (rep_q == '0);
  // Abort in SEND blocks a simultaneous load even on the final bit.
  assign accept    = ld.load_valid && ld.load_ready && !(sending && abort);

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    bit_d      = bit_q;
    rep_d      = rep_q;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    piso_din   = hold_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = SEND;
          hold_d    = ld.load_data;
          rep_d     = ld.load_reps;
          bit_d     = '0;
          piso_load = 1'b1;
          piso_din  = ld.load_data;
        end
      end
      SEND: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!last_bit) begin
          piso_shift = 1'b1;
          bit_d      = bit_q + 1'b1;
        end else if (rep_q != '0) begin
          piso_load = 1'b1;
          rep_d     = rep_q - 1'b1;
          bit_d     = '0;
        end else if (accept) begin
          hold_d    = ld.load_data;
          rep_d     = ld.load_reps;
          bit_d     = '0;
          piso_load = 1'b1;
          piso_din  = ld.load_data;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      bit_q   <= '0;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      bit_q   <= bit_d;
      rep_q   <= rep_d;
    end
  end

  seq_piso #(.WIDTH(WIDTH)) u_piso (
    .clk      (clk),
    .reset    (reset),
    .load     (piso_load),
    .shift_en (piso_shift),
    .din      (piso_din),
    .sout     (piso_bit)
  );

  assign ld.load_ready = (state_q == IDLE) || final_bit;
  assign busy          = sending;
  assign ser_valid     = sending;
  assign ser_out       = sending && piso_bit;
  assign ser_last      = final_bit;
endmodule
